// File: rtl/mdu_pkg.sv
// Shared MDU opcodes, default latencies and the pending-result record.
// Opcodes and latencies are also consumed by the hazard unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_MULT  = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_DIV   = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Result waiting for its commit edge; hold suppresses the commit.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hold;
  } mdu_res_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULTU) || (op == MDU_MULT);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider with sign fix-up.
// MDU_DIV0_HOLD_EN: exposes div0 so the commit can be suppressed.
module mdu_divider (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] q,
  output logic [31:0] r
`ifdef MDU_DIV0_HOLD_EN
  , output logic      div0
`endif
);

  logic        neg_a, neg_b, b_zero;
  logic [31:0] abs_a, abs_b, uq, ur;

  always_comb begin
    neg_a  = is_signed & a[31];
    neg_b  = is_signed & b[31];
    abs_a  = neg_a ? (~a + 32'd1) : a;
    abs_b  = neg_b ? (~b + 32'd1) : b;
    b_zero = (b == 32'd0);
    uq     = '0;
    ur     = '0;
    if (!b_zero) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    // INT_MIN / -1 lands on 0x80000000 naturally: |a|=2^31, signs cancel.
    q = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    r = neg_a ? (~ur + 32'd1) : ur;
    if (b_zero) begin
`ifdef MDU_DIV0_HOLD_EN
      q = '0;
      r = '0;
`else
      q = 32'hFFFF_FFFF;
      r = a;
`endif
    end
  end

`ifdef MDU_DIV0_HOLD_EN
  assign div0 = b_zero;
`endif

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency, result committed on cnt 1->0.
// MDU_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged at commit.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  E_MDU_OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_res_t         p_q, p_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic        mul_sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] div_q, div_r;
  logic        div_hold;

  // Sign/zero extension to 64 bits lets one multiplier serve mult and multu.
  always_comb begin
    mul_sgn = (E_MDU_OP == MDU_MULT);
    ext_a   = {{32{mul_sgn & A[31]}}, A};
    ext_b   = {{32{mul_sgn & B[31]}}, B};
    prod    = ext_a * ext_b;
  end

`ifdef MDU_DIV0_HOLD_EN
  logic div0;
  mdu_divider u_div (
    .a(A), .b(B), .is_signed(E_MDU_OP == MDU_DIV),
    .q(div_q), .r(div_r), .div0(div0)
  );
  assign div_hold = div0;
`else
  mdu_divider u_div (
    .a(A), .b(B), .is_signed(E_MDU_OP == MDU_DIV),
    .q(div_q), .r(div_r)
  );
  assign div_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      p_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    p_d   = p_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q == '0) begin
      if (start) begin
        if (is_mul_op(E_MDU_OP)) begin
          p_d   = '{hi: prod[63:32], lo: prod[31:0], hold: 1'b0};
          cnt_d = CNT_W'(MULT_CYCLES);
        end else if (is_div_op(E_MDU_OP)) begin
          p_d   = '{hi: div_r, lo: div_q, hold: div_hold};
          cnt_d = CNT_W'(DIV_CYCLES);
        end
      end else if (E_MDU_OP == MDU_MTHI) begin
        hi_d = A;
      end else if (E_MDU_OP == MDU_MTLO) begin
        lo_d = A;
      end
    end else begin
      // Anything presented while running is dropped; the hazard unit prevents it.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !p_q.hold) begin
        hi_d = p_q.hi;
        lo_d = p_q.lo;
      end
    end
  end

  always_comb begin
    busy = (cnt_q != '0);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, results, HI/LO moves, reset abort.
module tb_mdu;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULTU = 4'd1, OP_MULT = 4'd2,
                         OP_DIVU = 4'd3, OP_DIV = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  E_MDU_OP;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .E_MDU_OP(E_MDU_OP),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset === 1'b1 && busy === 1'b1 &&
        (start === 1'b1 || E_MDU_OP == OP_MTHI || E_MDU_OP == OP_MTLO))
      $display("WARNING: md request presented while busy at %0t", $time);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; E_MDU_OP = op; A = a; B = b;
    step();
    start = 1'b0; E_MDU_OP = OP_NONE;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise: got %b expected 1", name, busy); end
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL %s_pending_visible: got %h/%h expected %h/%h", name, HI, LO, m_hi, m_lo);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n !== exp_n) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_n); end
    chk({name, "_hi"}, HI, exp_hi);
    chk({name, "_lo"}, LO, exp_lo);
    m_hi = exp_hi; m_lo = exp_lo;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; E_MDU_OP = OP_NONE; A = '0; B = '0;
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_mult();
    run_md("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_div();
    run_md("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_intmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_md("divu_100_7", OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_md("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);
  endtask

  task automatic test_div0();
`ifdef MDU_DIV0_HOLD_EN
    run_md("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 10, m_hi, m_lo);
`else
    run_md("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 10, 32'h0000_1234, 32'hFFFF_FFFF);
`endif
  endtask

  task automatic test_ignored_ops();
    issue(4'd7, 32'h1111_1111, 32'd3);
    chk("op7_busy", {31'd0, busy}, 32'd0);
    issue(OP_NONE, 32'h2222_2222, 32'd3);
    chk("op0_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTHI, 32'h3333_3333, 32'd0);
    chk("mthi_with_start_hi", HI, m_hi);
    chk("ignored_lo", LO, m_lo);
  endtask

  task automatic test_back_to_back();
    int n;
    issue(OP_MULT, 32'd2, 32'd3);
    step(); step();
    E_MDU_OP = OP_MTHI; A = 32'h0000_DEAD;
    step();
    E_MDU_OP = OP_NONE;
    step();
    start = 1'b1; E_MDU_OP = OP_MULT; A = 32'd3; B = 32'd3;
    step();
    chk("b2b_commit_busy", {31'd0, busy}, 32'd0);
    chk("b2b_commit_hi", HI, 32'd0);
    chk("b2b_commit_lo", LO, 32'd6);
    step();
    start = 1'b0; E_MDU_OP = OP_NONE;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    chk("b2b_hold_lo", LO, 32'd6);
    n = 0;
    while (busy === 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL b2b_latency: got %0d expected 5", n); end
    chk("b2b_second_lo", LO, 32'd9);
    chk("b2b_second_hi", HI, 32'd0);
    m_hi = 32'd0; m_lo = 32'd9;
  endtask

  task automatic test_mthi_mtlo();
    E_MDU_OP = OP_MTHI; A = 32'h0000_AAAA;
    step();
    chk("mthi_hi", HI, 32'h0000_AAAA);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    E_MDU_OP = OP_MTLO; A = 32'h0000_5555;
    step();
    E_MDU_OP = OP_NONE;
    chk("mtlo_lo", LO, 32'h0000_5555);
    chk("mtlo_hi_kept", HI, 32'h0000_AAAA);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_reset_mid();
    issue(OP_MULT, 32'd2, 32'd3);
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_commit_hi", HI, 32'd0);
    chk("abort_no_commit_lo", LO, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignored_ops();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded `start` pulse, the 4-bit MDU opcode and the two forwarded operands. It runs mult/multu/div/divu over a fixed multi-cycle latency and owns the architectural HI/LO registers. It exposes `busy` so the hazard unit can stall md-class instructions in D, and it exposes committed HI/LO for mfhi/mflo selection.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1: clock, all state changes on rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `start`  in  1: one-cycle pulse; E-stage instruction is mult/multu/div/divu.
- `E_MDU_OP`  in  4: 1 multu, 2 mult, 3 divu, 4 div, 5 mthi, 6 mtlo, 0 none; other values are none.
- `A`  in  32: rs operand, already forwarded.
- `B`  in  32: rt operand, already forwarded.
- `busy`  out  1: operation in flight.
- `HI`  out  32: committed HI.
- `LO`  out  32: committed LO.

## Operation
- Internal state: `HI`, `LO`, pending registers `p_hi`/`p_lo`, and down-counter `cnt`.
- `cnt` width is enough to hold max(MULT_CYCLES, DIV_CYCLES).
- States: IDLE (`cnt`==0) and RUN (`cnt`!=0). `busy` = (`cnt`!=0), registered-derived, with no combinational path from `start`.
- IDLE, `start`=1, op 1–4: compute the result combinationally from A/B and capture it into `p_hi`/`p_lo`. Load `cnt` with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
- `start`=1 with op 0,5,6 or an undefined op: ignored.
- RUN: decrement `cnt` each edge. On the edge where `cnt` goes 1→0, HI←`p_hi` and LO←`p_lo`.
- multu: {p_hi,p_lo} = zero-extended A × B, 64 bits.
- mult: {p_hi,p_lo} = signed A × B, 64 bits.
- divu: p_lo = A/B, p_hi = A%B, unsigned.
- div: signed, quotient truncates toward zero, remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Division by zero: see Configuration.
- mthi (op 5) / mtlo (op 6): write HI/LO ←A at the edge, only when IDLE and `start`=0. No busy is raised.
- While busy: `start` and mthi/mtlo are ignored, and in-flight state is untouched. The hazard unit guarantees neither occurs. The bench flags any occurrence as a warning, not an error.
- HI/LO outputs never show pending values. mfhi/mflo read the committed value only.

## Timing
- Reset (async assert, low): HI=0, LO=0, `cnt`=0, `busy`=0, `p_hi`=`p_lo`=0. Release is synchronous to the next edge.
- Reset mid-operation aborts the operation. No commit occurs, and HI/LO read 0.
- If `start` is sampled at edge T, `busy`=1 during cycles T+1 … T+N, where N is the selected latency.
- HI/LO hold the new values from edge T+N onward. `busy`=0 in the same cycle.
- A `start` sampled at the edge where `cnt` goes 1→0 is still ignored, because the unit is busy at that edge. The next start is accepted one edge later.
- mthi/mtlo take effect at the sampling edge, with latency 1.
- An upstream stall condition uses `start | busy`. That OR is the hazard unit's job, not this block's.

## Configuration
- Macro `MDU_DIV0_HOLD_EN`:
  - Defined: div/divu with B==0 completes the full DIV_CYCLES busy window, but the commit leaves HI/LO unchanged.
  - Undefined: B==0 commits deterministic values, LO=0xFFFFFFFF and HI=A, for both signed and unsigned. No X is ever produced.

## Structure
- Shared package `mdu_pkg`:
  - opcode constants MDU_NONE=0, MDU_MULTU=1, MDU_MULT=2, MDU_DIVU=3, MDU_DIV=4, MDU_MTHI=5, MDU_MTLO=6;
  - default latency constants, also used by the hazard unit.
- Sub-module `mdu_divider`: combinational signed/unsigned 32-bit divider. It handles the sign fix-up, INT_MIN/−1 and the div-by-zero values, under the same macro. The multiply stays inline.

## Test plan
- Reset, then `mult` with A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles; after that, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- `multu` with A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 at edge T+5.
- `div` with A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- `div` 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `divu` with B=0 and A=0x1234:
  - with macro defined: HI/LO unchanged;
  - without macro: LO=0xFFFFFFFF, HI=0x1234.
- mthi 0xAAAA, then mtlo 0x5555 → HI/LO update next edge with no busy. Then start `mult`, assert reset low at cycle T+3 → HI=LO=0 and `busy`=0 immediately, with no commit after release.
